hot_addr_drain: RTL and testbench
=================================

Name: hot_addr_drain

Overview:
Parametrised successor to the hot tracker's top-K drain stage. On each tracker snapshot it captures NUM_ENTRY (addr, cnt) pairs and drops entries below a programmable count threshold. It suppresses addresses migrated recently (a HIST_DEPTH-entry history CAM), limits migrations per epoch, and streams survivors to the migration engine over a valid/ready port. It sits between the sorted-CAM top-K output and the migration controller, and replaces the fixed all-ones-sentinel shift drain.

Parameters:
ADDR_SIZE, 22, address width; all-ones is the empty-slot sentinel
CNT_SIZE, 32, count width
NUM_ENTRY, 25, snapshot depth (K)
INDEX_SIZE, 5, $clog2(NUM_ENTRY)
HIST_DEPTH, 16, recently-migrated history entries; power of 2, at least 2
HIST_IDX, 4, $clog2(HIST_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous active-low reset
snap_valid  in  1  one-cycle snapshot strobe (tracker query_ready)
snap_addr  in  NUM_ENTRY*ADDR_SIZE  flattened top-K addresses, entry 0 in LSBs, hottest first
snap_cnt  in  NUM_ENTRY*CNT_SIZE  flattened matching counts
cnt_threshold  in  CNT_SIZE  minimum count to migrate; sampled on snapshot capture
max_mig  in  INDEX_SIZE+1  per-epoch migration cap; 0 = unlimited; sampled on capture
hist_clr  in  1  clears all history valid bits
mig_addr_valid  out  1  migration address valid
mig_addr  out  ADDR_SIZE  migration address
mig_addr_ready  in  1  consumer ready
busy  out  1  state != IDLE
epoch_done  out  1  one-cycle pulse when a drain completes
snap_drop_cnt  out  16  saturating count of snapshots ignored while busy

Behaviour:
- Reset: state IDLE; all entry valid bits 0; entry addr all-ones; history valid bits 0; history write pointer 0; sent counter 0; snap_drop_cnt 0; mig_addr_valid 0; mig_addr all-ones; epoch_done 0; busy 0.
- FSM states: IDLE, DRAIN, DONE.
- IDLE, snap_valid=1 (cycle t): capture the entries, latch cnt_threshold and max_mig, clear the sent counter, go to DRAIN at t+1.
  - entry i valid = (addr_i != all-ones) && (cnt_i >= cnt_threshold), unsigned compare.
- DRAIN: head = entry 0. mig_addr = head addr.
  - mig_addr_valid = head valid && !hist_hit, combinational from registers. hist_hit = head addr matches any valid history entry.
  - Head invalid or hist_hit: shift entries down by one (entry NUM_ENTRY-1 gets valid 0, addr all-ones). One skip per cycle, no output.
  - Handshake (mig_addr_valid && mig_addr_ready): shift; write head addr into history[wr_ptr] with valid 1; wr_ptr increments modulo HIST_DEPTH, overwriting the oldest entry; sent counter increments.
  - mig_addr_valid high with ready low: hold all state. mig_addr stays stable until accepted.
  - Exit to DONE when the valid vector is all 0, or when max_mig != 0 and sent == max_mig. Exit is evaluated on registered state, so the cycle after the final handshake moves to DONE.
- DONE: epoch_done=1 for exactly one cycle, then IDLE. Remaining entries are discarded (valid cleared).
- snap_valid in DRAIN or DONE: ignored; snap_drop_cnt increments, saturating at 16'hFFFF. The in-flight drain is never aborted.
- hist_clr: clears all history valid bits next edge; wr_ptr resets to 0.
  - If a handshake occurs in the same cycle, the clear applies first, then the insert is written at index 0 (valid 1) and wr_ptr becomes 1.
- Latency: snapshot strobe to first mig_addr_valid = 1 cycle when entry 0 is eligible; +1 cycle per skipped head.
- Empty snapshot (all ineligible): DRAIN for 1 cycle, then DONE, with no output.
- Async reset mid-drain: everything returns to reset values immediately; mig_addr_valid drops with no handshake.

Decomposition:
- Package hot_tracker_pkg: state enum {IDLE, DRAIN, DONE}; ADDR_INVALID all-ones constant function of ADDR_SIZE; entry struct {valid, addr}.
- Sub-module mig_history: HIST_DEPTH-entry circular CAM with lookup addr, hit out, insert, clear. Its same-cycle clear+insert rule is as stated above.
- Top: snapshot capture/threshold, shift register, FSM, counters.

Test Plan:
- Snapshot addrs 0x10,0x20,0x30, rest all-ones, cnts 9,5,1, threshold 4, ready=1 -> mig_addr 0x10 at t+1, 0x20 at t+2; 0x30 never sent; epoch_done at t+4.
- Same snapshot, ready low 5 cycles -> mig_addr_valid held, mig_addr stable at 0x10 throughout; resumes on ready.
- Two identical snapshots {0x10,0x20}, threshold 0, second after epoch_done -> second epoch sends nothing; after hist_clr a third snapshot sends 0x10,0x20.
- max_mig=2, 5 eligible entries -> exactly 2 handshakes, then epoch_done; snap_valid pulsed during drain -> snap_drop_cnt=1 and output sequence unchanged.
- HIST_DEPTH+1 distinct migrations over epochs, then resend first addr -> it is sent (oldest evicted); hist_clr coincident with a handshake -> only that address remains suppressed.
- rst_n asserted while mig_addr_valid=1 -> all outputs at reset values immediately; next snapshot drains normally.

Source files
------------

// File: rtl/hot_tracker_pkg.sv
// Shared types for the hot-tracker drain path: FSM states, entry record,
// and the all-ones empty-slot sentinel.
package hot_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_e;

    localparam int ADDR_SIZE_DEF = 22;

    typedef struct packed {
        logic                     valid;
        logic [ADDR_SIZE_DEF-1:0] addr;
    } entry_t;

    // All-ones pattern of the given width (width up to 64).
    function automatic logic [63:0] addr_invalid(input int width);
        if (width >= 64)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/mig_history.sv
// Circular CAM of recently migrated addresses; the oldest entry is
// overwritten once the ring is full.
module mig_history #(
    parameter int ADDR_SIZE  = 22,
    parameter int HIST_DEPTH = 16,
    parameter int HIST_IDX   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE-1:0] lookup_addr,
    output logic                 hit,
    input  logic                 insert,
    input  logic [ADDR_SIZE-1:0] insert_addr,
    input  logic                 clr
);

    logic [HIST_DEPTH-1:0] h_valid;
    logic [ADDR_SIZE-1:0]  h_addr [HIST_DEPTH];
    logic [HIST_IDX-1:0]   wr_ptr;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (h_valid[i] && (h_addr[i] == lookup_addr))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid <= '0;
            wr_ptr  <= '0;
            for (int i = 0; i < HIST_DEPTH; i++)
                h_addr[i] <= '0;
        end else if (clr) begin
            // A clear wins over older contents, but a same-cycle insert still lands at slot 0.
            h_valid <= '0;
            wr_ptr  <= '0;
            if (insert) begin
                h_valid[0] <= 1'b1;
                h_addr[0]  <= insert_addr;
                wr_ptr     <= HIST_IDX'(1);
            end
        end else if (insert) begin
            h_valid[wr_ptr] <= 1'b1;
            h_addr[wr_ptr]  <= insert_addr;
            wr_ptr          <= wr_ptr + HIST_IDX'(1);
        end
    end

endmodule

// File: rtl/hot_addr_drain.sv
// Top-K snapshot drain: thresholds a tracker snapshot, filters recent
// migrations and streams survivors over a valid/ready port.
//   state | meaning
//   IDLE  | waiting for a snapshot strobe
//   DRAIN | presenting/skipping the head entry, shifting down each step
//   DONE  | one-cycle epoch_done, leftover entries discarded
module hot_addr_drain
    import hot_tracker_pkg::*;
#(
    parameter int ADDR_SIZE  = 22,
    parameter int CNT_SIZE   = 32,
    parameter int NUM_ENTRY  = 25,
    parameter int INDEX_SIZE = 5,
    parameter int HIST_DEPTH = 16,
    parameter int HIST_IDX   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           snap_valid,
    input  logic [NUM_ENTRY*ADDR_SIZE-1:0] snap_addr,
    input  logic [NUM_ENTRY*CNT_SIZE-1:0]  snap_cnt,
    input  logic [CNT_SIZE-1:0]            cnt_threshold,
    input  logic [INDEX_SIZE:0]            max_mig,
    input  logic                           hist_clr,
    output logic                           mig_addr_valid,
    output logic [ADDR_SIZE-1:0]           mig_addr,
    input  logic                           mig_addr_ready,
    output logic                           busy,
    output logic                           epoch_done,
    output logic [15:0]                    snap_drop_cnt
);

    localparam logic [ADDR_SIZE-1:0] ADDR_INVALID = ADDR_SIZE'(addr_invalid(ADDR_SIZE));

    state_e               state;
    logic [NUM_ENTRY-1:0] ent_valid;
    logic [ADDR_SIZE-1:0] ent_addr [NUM_ENTRY];
    logic [INDEX_SIZE:0]  max_q;
    logic [INDEX_SIZE:0]  sent;
    logic                 hist_hit;
    logic                 cap_hit;
    logic                 handshake;

    // Gating on the cap keeps a valid head from being offered once the budget is spent.
    assign cap_hit        = (max_q != '0) && (sent == max_q);
    assign mig_addr_valid = (state == DRAIN) && ent_valid[0] && !hist_hit && !cap_hit;
    assign mig_addr       = ent_addr[0];
    assign handshake      = mig_addr_valid && mig_addr_ready;
    assign busy           = (state != IDLE);

    mig_history #(
        .ADDR_SIZE (ADDR_SIZE),
        .HIST_DEPTH(HIST_DEPTH),
        .HIST_IDX  (HIST_IDX)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_addr(ent_addr[0]),
        .hit        (hist_hit),
        .insert     (handshake),
        .insert_addr(ent_addr[0]),
        .clr        (hist_clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ent_valid     <= '0;
            max_q         <= '0;
            sent          <= '0;
            snap_drop_cnt <= '0;
            epoch_done    <= 1'b0;
            for (int i = 0; i < NUM_ENTRY; i++)
                ent_addr[i] <= ADDR_INVALID;
        end else begin
            epoch_done <= 1'b0;
            if (snap_valid && (state != IDLE) && (snap_drop_cnt != 16'hFFFF))
                snap_drop_cnt <= snap_drop_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (snap_valid) begin
                        for (int i = 0; i < NUM_ENTRY; i++) begin
                            ent_addr[i]  <= snap_addr[i*ADDR_SIZE +: ADDR_SIZE];
                            ent_valid[i] <= (snap_addr[i*ADDR_SIZE +: ADDR_SIZE] != ADDR_INVALID)
                                         && (snap_cnt[i*CNT_SIZE +: CNT_SIZE] >= cnt_threshold);
                        end
                        max_q <= max_mig;
                        sent  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((ent_valid == '0) || cap_hit) begin
                        state      <= DONE;
                        epoch_done <= 1'b1;
                    end else if (!ent_valid[0] || hist_hit || handshake) begin
                        ent_valid <= ent_valid >> 1;
                        for (int i = 0; i < NUM_ENTRY - 1; i++)
                            ent_addr[i] <= ent_addr[i+1];
                        ent_addr[NUM_ENTRY-1] <= ADDR_INVALID;
                        if (handshake)
                            sent <= sent + (INDEX_SIZE+1)'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ent_valid <= '0;
                    for (int i = 0; i < NUM_ENTRY; i++)
                        ent_addr[i] <= ADDR_INVALID;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hot_addr_drain.sv
// Scenario bench for hot_addr_drain: expected migrations are queued at
// stimulus time and compared against the handshakes seen on the port.
module tb_hot_addr_drain;

    localparam int AS = 22;
    localparam int CS = 32;
    localparam int NE = 25;
    localparam int IS = 5;
    localparam int HD = 16;
    localparam int HI = 4;
    localparam logic [AS-1:0] INV = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             snap_valid = 1'b0;
    logic [NE*AS-1:0] snap_addr = '1;
    logic [NE*CS-1:0] snap_cnt = '0;
    logic [CS-1:0]    cnt_threshold = '0;
    logic [IS:0]      max_mig = '0;
    logic             hist_clr = 1'b0;
    logic             mig_addr_valid;
    logic [AS-1:0]    mig_addr;
    logic             mig_addr_ready = 1'b0;
    logic             busy;
    logic             epoch_done;
    logic [15:0]      snap_drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [AS-1:0] exp_q[$];
    logic [AS-1:0] got_q[$];
    int            got_cyc[$];

    hot_addr_drain #(
        .ADDR_SIZE(AS), .CNT_SIZE(CS), .NUM_ENTRY(NE),
        .INDEX_SIZE(IS), .HIST_DEPTH(HD), .HIST_IDX(HI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid),
        .snap_addr(snap_addr), .snap_cnt(snap_cnt),
        .cnt_threshold(cnt_threshold), .max_mig(max_mig), .hist_clr(hist_clr),
        .mig_addr_valid(mig_addr_valid), .mig_addr(mig_addr),
        .mig_addr_ready(mig_addr_ready), .busy(busy),
        .epoch_done(epoch_done), .snap_drop_cnt(snap_drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && mig_addr_valid && mig_addr_ready) begin
            got_q.push_back(mig_addr);
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_snap();
        snap_addr = '1;
        snap_cnt  = '0;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic set_entry(input int i, input logic [AS-1:0] a, input logic [CS-1:0] c);
        snap_addr[i*AS +: AS] = a;
        snap_cnt[i*CS +: CS]  = c;
    endtask

    task automatic clear_hist();
        @(posedge clk); #1 hist_clr = 1'b1;
        @(posedge clk); #1 hist_clr = 1'b0;
    endtask

    // Returns t = cycle stamp of the capture edge; extra holds the strobe one more edge.
    task automatic start_snap(input bit extra, output int t);
        @(posedge clk); #1 snap_valid = 1'b1;
        @(posedge clk); #1 t = cyc;
        if (extra) begin
            @(posedge clk); #1;
        end
        snap_valid = 1'b0;
    endtask

    task automatic run_epoch(input int t, output int rel, output bit to);
        to  = 1'b1;
        rel = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (epoch_done) begin
                rel = cyc - t + 1;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (mig_addr_valid !== 1'b0 || mig_addr !== INV || busy !== 1'b0 ||
            epoch_done !== 1'b0 || snap_drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b a=%h busy=%b done=%b drop=%0d want 0 %h 0 0 0",
                     mig_addr_valid, mig_addr, busy, epoch_done, snap_drop_cnt, INV);
        end
    endtask

    task automatic test_basic();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_snap();
        set_entry(0, 22'h10, 9); set_entry(1, 22'h20, 5); set_entry(2, 22'h30, 1);
        cnt_threshold = 4; max_mig = 0; mig_addr_ready = 1'b1;
        exp_q.push_back(22'h10); exp_q.push_back(22'h20);
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || rel != 4) begin
            miscompares++;
            $display("FAIL basic_done_cycle got %0d (timeout %0b) want 4", rel, to);
        end
        vectors++;
        if (got_q.size() != 2 || got_cyc[0] - t + 1 != 1 || got_cyc[1] - t + 1 != 2) begin
            miscompares++;
            $display("FAIL basic_latency got n=%0d want 2 sends at cycles 1,2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL basic_addr got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_stall();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_hist();
        clear_snap();
        set_entry(0, 22'h10, 9); set_entry(1, 22'h20, 5); set_entry(2, 22'h30, 1);
        cnt_threshold = 4; mig_addr_ready = 1'b0;
        exp_q.push_back(22'h10); exp_q.push_back(22'h20);
        start_snap(1'b0, t);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (mig_addr_valid !== 1'b1 || mig_addr !== 22'h10) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d got v=%b a=%h want 1 000010", k, mig_addr_valid, mig_addr);
            end
        end
        @(posedge clk); #1 mig_addr_ready = 1'b1;
        run_epoch(t, rel, to);
        vectors++;
        if (to || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL stall_count got %0d (timeout %0b) want 2", got_q.size(), to);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL stall_addr got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_history();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_hist();
        clear_snap();
        cnt_threshold = 0; mig_addr_ready = 1'b1;
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || rel != 2 || got_q.size() != 0) begin
            miscompares++;
            $display("FAIL empty_snap got done=%0d n=%0d want done=2 n=0", rel, got_q.size());
        end
        for (int ep = 0; ep < 3; ep++) begin
            clear_snap();
            set_entry(0, 22'h10, 1); set_entry(1, 22'h20, 1);
            if (ep != 1) begin
                exp_q.push_back(22'h10); exp_q.push_back(22'h20);
            end
            if (ep == 2) clear_hist();
            start_snap(1'b0, t);
            run_epoch(t, rel, to);
            vectors++;
            if (to || got_q.size() != exp_q.size() || (ep == 1 && rel != 4)) begin
                miscompares++;
                $display("FAIL hist_epoch%0d got n=%0d done=%0d want n=%0d", ep, got_q.size(), rel, exp_q.size());
            end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                a = got_q.pop_front(); e = exp_q.pop_front();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL hist_addr got %h want %h", a, e);
                end
            end
        end
    endtask

    task automatic test_max_mig();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_hist();
        clear_snap();
        for (int i = 0; i < 5; i++) set_entry(i, AS'(22'h100 * (i + 1)), 50);
        cnt_threshold = 10; max_mig = 2; mig_addr_ready = 1'b1;
        exp_q.push_back(22'h100); exp_q.push_back(22'h200);
        start_snap(1'b1, t);
        run_epoch(t, rel, to);
        max_mig = 0;
        vectors++;
        if (to || rel != 4 || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL max_mig got n=%0d done=%0d want n=2 done=4", got_q.size(), rel);
        end
        vectors++;
        if (snap_drop_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL snap_drop got %0d want 1", snap_drop_cnt);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL max_addr got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_evict();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_hist();
        clear_snap();
        cnt_threshold = 0; mig_addr_ready = 1'b1;
        for (int i = 0; i <= HD; i++) begin
            set_entry(i, AS'(22'h1000 + i), 1);
            exp_q.push_back(AS'(22'h1000 + i));
        end
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || got_q.size() != HD + 1) begin
            miscompares++;
            $display("FAIL evict_fill got %0d want %0d", got_q.size(), HD + 1);
        end
        got_q.delete(); exp_q.delete();
        // 0x1001 and 0x1010 still in history; 0x1000 was evicted by 0x1010.
        set_entry(0, 22'h1001, 1); set_entry(1, 22'h1000, 1); set_entry(2, 22'h1010, 1);
        for (int i = 3; i <= HD; i++) set_entry(i, INV, 1);
        exp_q.push_back(22'h1000);
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || got_q.size() != 1) begin
            miscompares++;
            $display("FAIL evict_count got %0d want 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL evict_addr got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_clr_handshake();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_hist();
        clear_snap();
        set_entry(0, 22'h0A, 1); set_entry(1, 22'h0B, 1);
        cnt_threshold = 0; mig_addr_ready = 1'b1;
        start_snap(1'b0, t);
        @(posedge clk); #1 hist_clr = 1'b1;
        @(posedge clk); #1 hist_clr = 1'b0;
        run_epoch(t, rel, to);
        vectors++;
        if (to || got_q.size() != 2) begin
            miscompares++;
            $display("FAIL clr_hs_first got %0d want 2", got_q.size());
        end
        got_q.delete();
        exp_q.push_back(22'h0A);
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || got_q.size() != 1) begin
            miscompares++;
            $display("FAIL clr_hs_count got %0d want 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL clr_hs_addr got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_async_reset();
        int t, rel;
        bit to;
        logic [AS-1:0] a, e;
        clear_snap();
        set_entry(0, 22'h77, 1);
        cnt_threshold = 0; mig_addr_ready = 1'b0;
        start_snap(1'b0, t);
        @(negedge clk);
        vectors++;
        if (mig_addr_valid !== 1'b1 || mig_addr !== 22'h77) begin
            miscompares++;
            $display("FAIL rst_pre got v=%b a=%h want 1 000077", mig_addr_valid, mig_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (mig_addr_valid !== 1'b0 || mig_addr !== INV || busy !== 1'b0 ||
            epoch_done !== 1'b0 || snap_drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_async got v=%b a=%h busy=%b drop=%0d want 0 %h 0 0",
                     mig_addr_valid, mig_addr, busy, snap_drop_cnt, INV);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        mig_addr_ready = 1'b1;
        exp_q.push_back(22'h77);
        start_snap(1'b0, t);
        run_epoch(t, rel, to);
        vectors++;
        if (to || rel != 3 || got_q.size() != 1) begin
            miscompares++;
            $display("FAIL rst_recover got n=%0d done=%0d want n=1 done=3", got_q.size(), rel);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL rst_addr got %h want %h", a, e);
            end
        end
    endtask

    initial begin
        #23 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_history();
        test_max_mig();
        test_evict();
        test_clr_handshake();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
